packetgen_flow_scheduler: RTL and testbench
===========================================

# packetgen_flow_scheduler

Rate scheduler for the multi-flow packet generator. It keeps a fixed-point token-bucket credit counter per flow and picks the next eligible flow by round-robin. It issues one grant at a time to the frame builder over a valid/ready handshake. The frame builder then emits one MAC frame of the granted flow's size and ID. Sustained per-flow bandwidth is therefore set by the configured per-cycle credit rate, not by free-running counters in the datapath.

## Interface
- N_FLOWS, 4: number of flows, 1..16
- SIZE_WIDTH, 11: frame size field width, in bytes
- RATE_WIDTH, 16: per-cycle credit increment width
- FRAC_BITS, 8: fractional bits of credit; 1 byte = 2^FRAC_BITS credit units
- CREDIT_WIDTH, 32: credit counter width; must be ≥ SIZE_WIDTH+FRAC_BITS+1
- FLOW_W, derived: max(1, clog2(N_FLOWS))
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- cfg_enable  in  N_FLOWS  per-flow enable
- cfg_rate  in  N_FLOWS*RATE_WIDTH  credit added per cycle, in 1/2^FRAC_BITS bytes; flow i occupies [i*RATE_WIDTH +: RATE_WIDTH]
- cfg_size  in  N_FLOWS*SIZE_WIDTH  frame size in bytes; 0 is treated as disabled
- grant_valid  out  1  grant offered
- grant_ready  in  1  frame builder accepts the grant
- grant_flow  out  FLOW_W  granted flow index
- grant_size  out  SIZE_WIDTH  granted frame size, sampled at grant
- grant_count  out  32  total accepted grants; wraps at 2^32
- eligible  out  N_FLOWS  registered per-flow eligibility, for status

## Operation
- Cost of flow i: cost[i] = cfg_size[i] << FRAC_BITS, zero-extended to CREDIT_WIDTH.
- Credit update, every cycle, per flow:
  - Flow disabled (cfg_enable[i]=0 or cfg_size[i]=0): credit[i] <= 0.
  - Otherwise: credit[i] <= sat(credit[i] + cfg_rate[i] − (accept && grant_flow==i ? cost_latched : 0)).
  - sat clamps at 2^CREDIT_WIDTH−1. The add is computed one bit wider, so no underflow can occur: a grant only exists when credit ≥ cost.
- Eligibility, combinational from registered credit: elig[i] = enabled[i] && credit[i] ≥ cost[i]. The eligible output is elig registered once.
- Arbiter: round-robin over elig.
  - Search starts at last_grant+1 and wraps modulo N_FLOWS.
  - last_grant resets to N_FLOWS−1, so flow 0 has first priority.
  - A flow being granted (GRANT state) is masked from the search.
- FSM:
  - IDLE: if any elig, latch the winner into grant_flow and its size into grant_size and cost_latched, then go to GRANT. Otherwise stay.
  - GRANT: grant_valid=1. On grant_ready: deduct cost_latched, last_grant <= grant_flow, increment grant_count, go to IDLE.
- Grants are never retracted. If cfg_enable or cfg_size changes while in GRANT, grant_flow and grant_size stay stable until accepted. If the flow has been disabled, its credit is forced to 0 and the deduction is ignored.
- cfg changes while in IDLE take effect on the next cycle's eligibility.

## Timing
- Reset values: grant_valid=0, grant_flow=0, grant_size=0, grant_count=0, eligible=0, all credits 0, FSM=IDLE, last_grant=N_FLOWS−1.
- Reset asserted mid-grant drops grant_valid immediately (asynchronous) and loses all credit.
- Latency: a credit crossing cost at edge k gives grant_valid high after edge k+1.
- Accept occurs at the edge where grant_valid && grant_ready. grant_valid deasserts after that edge.
- Minimum spacing between grants is 2 cycles: IDLE→GRANT, then accept in the same cycle grant_valid first rises.
- Peak throughput is therefore one grant per 2 cycles.
- Credit keeps accruing while in GRANT. The increment and the deduction land on the same edge.
- Simultaneous eligibility of several flows: the lowest index at or after last_grant+1 (mod N_FLOWS) wins.

## Test plan
- Single flow, rate=256, size=64, FRAC_BITS=8, enable at t0, grant_ready tied 1:
  - first grant_valid after edge 65 with flow 0 and size 64.
  - Grants then repeat every 64 cycles.
  - After 10 grants, grant_count=10.
- Four flows, rate=0xFFFF, size=64, all enabled, ready=1:
  - grant_flow sequence is 0,1,2,3,0,...
  - One grant every 2 cycles.
  - No flow is ever granted twice in a row.
- Backpressure: hold grant_ready=0 for 100 cycles in GRANT.
  - grant_valid, grant_flow and grant_size stay stable.
  - Credit keeps rising: 100·rate added.
  - On release, exactly one deduction of the cost.
- Saturation: rate=0xFFFF, no grant acceptance (ready=0) for 2^16 cycles.
  - credit clamps at 0xFFFFFFFF with no wrap.
  - The first accept then yields 0xFFFFFFFF − cost + rate, saturated.
- Disable mid-grant: clear cfg_enable[1] while flow 1 is granted.
  - The grant is still completed on ready.
  - credit[1]=0 afterwards and eligible[1]=0.
  - No further grants to flow 1.
  - Set cfg_size=0 on an enabled flow: the flow is never granted.
- Asynchronous reset: assert rst_n=0 mid-GRANT, between edges.
  - grant_valid=0 immediately.
  - After release, the first grant goes to flow 0.
  - grant_count=0.

Source files
------------

// File: rtl/packetgen_flow_scheduler.sv
// Rate scheduler for the multi-flow packet generator: per-flow fixed-point token-bucket credit,
// round-robin pick among eligible flows, one grant outstanding to the frame builder at a time.
module packetgen_flow_scheduler #(
   parameter int unsigned N_FLOWS      = 4,
   parameter int unsigned SIZE_WIDTH   = 11,
   parameter int unsigned RATE_WIDTH   = 16,
   parameter int unsigned FRAC_BITS    = 8,
   parameter int unsigned CREDIT_WIDTH = 32,
   parameter int unsigned FLOW_W       = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [N_FLOWS-1:0]             cfg_enable,
   input  logic [N_FLOWS*RATE_WIDTH-1:0]  cfg_rate,
   input  logic [N_FLOWS*SIZE_WIDTH-1:0]  cfg_size,
   output logic                           grant_valid,
   input  logic                           grant_ready,
   output logic [FLOW_W-1:0]              grant_flow,
   output logic [SIZE_WIDTH-1:0]          grant_size,
   output logic [31:0]                    grant_count,
   output logic [N_FLOWS-1:0]             eligible
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e                               state_q;
   logic [N_FLOWS-1:0][CREDIT_WIDTH-1:0] credit_q, credit_d, cost;
   logic [N_FLOWS-1:0][SIZE_WIDTH-1:0]   size_arr;
   logic [N_FLOWS-1:0][RATE_WIDTH-1:0]   rate_arr;
   logic [N_FLOWS-1:0]                   enabled, elig, search;
   logic [CREDIT_WIDTH-1:0]              cost_latched_q;
   logic [FLOW_W-1:0]                    last_grant_q, winner;
   logic                                 found, accept;

   assign accept = grant_valid && grant_ready;

   always_comb begin
      for (int i = 0; i < N_FLOWS; i++) begin
         size_arr[i] = cfg_size[i*SIZE_WIDTH +: SIZE_WIDTH];
         rate_arr[i] = cfg_rate[i*RATE_WIDTH +: RATE_WIDTH];
         cost[i]     = '0;
         cost[i][FRAC_BITS +: SIZE_WIDTH] = size_arr[i];
         enabled[i]  = cfg_enable[i] && (size_arr[i] != '0);
         elig[i]     = enabled[i] && (credit_q[i] >= cost[i]);
      end
   end

   // One extra bit absorbs the add; the clamp-to-zero branch only guards a flow that was
   // disabled and re-enabled while its grant was still pending.
   always_comb begin
      logic [CREDIT_WIDTH:0] sum, ded, diff;
      sum  = '0;
      ded  = '0;
      diff = '0;
      for (int i = 0; i < N_FLOWS; i++) begin
         sum  = {1'b0, credit_q[i]} + (CREDIT_WIDTH+1)'(rate_arr[i]);
         ded  = (accept && (grant_flow == FLOW_W'(i))) ? {1'b0, cost_latched_q} : '0;
         diff = sum - ded;
         if (!enabled[i] || (sum < ded)) begin
            credit_d[i] = '0;
         end else if (diff[CREDIT_WIDTH]) begin
            credit_d[i] = '1;
         end else begin
            credit_d[i] = diff[CREDIT_WIDTH-1:0];
         end
      end
   end

   always_comb begin
      int unsigned idx;
      search = elig;
      if (state_q == StGrant) begin
         search[grant_flow] = 1'b0;
      end
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int unsigned k = 0; k < N_FLOWS; k++) begin
         idx = 32'(last_grant_q) + 32'd1 + k;
         if (idx >= N_FLOWS) begin
            idx = idx - N_FLOWS;
         end
         if (!found && search[idx[FLOW_W-1:0]]) begin
            found  = 1'b1;
            winner = idx[FLOW_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_q <= '0;
         eligible <= '0;
      end else begin
         credit_q <= credit_d;
         eligible <= elig;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         grant_valid    <= 1'b0;
         grant_flow     <= '0;
         grant_size     <= '0;
         cost_latched_q <= '0;
         last_grant_q   <= FLOW_W'(N_FLOWS - 1);
         grant_count    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (found) begin
                  grant_flow     <= winner;
                  grant_size     <= size_arr[winner];
                  cost_latched_q <= cost[winner];
                  grant_valid    <= 1'b1;
                  state_q        <= StGrant;
               end
            end
            StGrant: begin
               if (grant_ready) begin
                  grant_valid  <= 1'b0;
                  last_grant_q <= grant_flow;
                  grant_count  <= grant_count + 32'd1;
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_packetgen_flow_scheduler.sv
// Bench for packetgen_flow_scheduler: latency table, directed corner sequences and a randomized
// run checked every cycle against a token-bucket reference model.
module tb_packetgen_flow_scheduler;

   localparam int N  = 4;
   localparam int SW = 11;
   localparam int RW = 16;
   localparam int FB = 8;
   localparam int CW = 32;
   localparam int FW = 2;
   localparam longint MAXC = 64'hFFFF_FFFF;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    cfg_enable = '0;
   logic [N*RW-1:0] cfg_rate = '0;
   logic [N*SW-1:0] cfg_size = '0;
   logic            grant_valid;
   logic            grant_ready = 1'b0;
   logic [FW-1:0]   grant_flow;
   logic [SW-1:0]   grant_size;
   logic [31:0]     grant_count;
   logic [N-1:0]    eligible;

   int n_checks = 0;
   int n_errors = 0;

   packetgen_flow_scheduler #(
      .N_FLOWS(N), .SIZE_WIDTH(SW), .RATE_WIDTH(RW), .FRAC_BITS(FB), .CREDIT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_rate(cfg_rate),
      .cfg_size(cfg_size), .grant_valid(grant_valid), .grant_ready(grant_ready),
      .grant_flow(grant_flow), .grant_size(grant_size), .grant_count(grant_count),
      .eligible(eligible)
   );

   always #5 clk = ~clk;

   // ---------------- reference model: token buckets + a pending-grant record ----------------
   longint    m_credit [N];
   bit        m_busy;
   int        m_flow, m_size, m_last;
   longint    m_cost;
   bit [31:0] m_count;
   bit [N-1:0] m_elig;

   function automatic bit f_en(int i);
      return cfg_enable[i] && (cfg_size[i*SW +: SW] != 0);
   endfunction
   function automatic longint f_cost(int i);
      return longint'(cfg_size[i*SW +: SW]) * (longint'(1) << FB);
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      bit acc, pick;
      bit [N-1:0] el;
      longint nc;
      int idx;
      if (!rst_n) begin
         for (int i = 0; i < N; i++) m_credit[i] = 0;
         m_busy = 0; m_flow = 0; m_size = 0; m_cost = 0; m_last = N - 1; m_count = 0; m_elig = '0;
      end else begin
         acc = m_busy && grant_ready;
         for (int i = 0; i < N; i++) el[i] = f_en(i) && (m_credit[i] >= f_cost(i));
         for (int i = 0; i < N; i++) begin
            if (!f_en(i)) nc = 0;
            else nc = m_credit[i] + longint'(cfg_rate[i*RW +: RW]) - ((acc && m_flow == i) ? m_cost : 0);
            if (nc > MAXC) nc = MAXC;
            if (nc < 0) nc = 0;
            m_credit[i] = nc;
         end
         m_elig = el;
         if (m_busy) begin
            if (acc) begin
               m_busy = 0; m_last = m_flow; m_count = m_count + 1;
            end
         end else begin
            pick = 0;
            for (int k = 1; k <= N; k++) begin
               idx = (m_last + k) % N;
               if (!pick && el[idx]) begin
                  pick = 1; m_busy = 1; m_flow = idx;
                  m_size = int'(cfg_size[idx*SW +: SW]); m_cost = f_cost(idx);
               end
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      bit bad;
      logic [N*CW-1:0] mc;
      if (rst_n) begin
         for (int i = 0; i < N; i++) mc[i*CW +: CW] = m_credit[i][CW-1:0];
         bad = (grant_valid !== m_busy) || (grant_flow !== FW'(m_flow)) ||
               (grant_size !== SW'(m_size)) || (grant_count !== m_count) ||
               (eligible !== m_elig) || (dut.credit_q !== mc);
         n_checks++;
         if (bad) begin
            n_errors++;
            $display("FAIL model_compare t=%0t: got v=%0b f=%0d s=%0d cnt=%0d el=%b cr=%h, expected v=%0b f=%0d s=%0d cnt=%0d el=%b cr=%h",
                     $time, grant_valid, grant_flow, grant_size, grant_count, eligible, dut.credit_q,
                     m_busy, m_flow, m_size, m_count, m_elig, mc);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   task automatic set_flow(input int i, input bit en, input int unsigned rate, input int unsigned size);
      cfg_enable[i]        = en;
      cfg_rate[i*RW +: RW] = RW'(rate);
      cfg_size[i*SW +: SW] = SW'(size);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; cfg_enable = '0; cfg_rate = '0; cfg_size = '0; grant_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", grant_valid, 0);
      chk("rst_flow", grant_flow, 0);
      chk("rst_size", grant_size, 0);
      chk("rst_count", grant_count, 0);
      chk("rst_eligible", eligible, 0);
      for (int i = 0; i < N; i++) chk("rst_credit", dut.credit_q[i], 0);
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      while (!grant_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!grant_valid) begin
         n_checks++; n_errors++;
         $display("FAIL wait_valid: grant_valid=0 after %0d cycles, required 1", n);
      end
   endtask

   typedef struct {
      int unsigned rate;
      int unsigned size;
      int          exp_edge;
   } vec_t;
   vec_t vecs [5];

   initial begin
      int n, e, last, ng, prev, g3, g_rand;
      vecs[0] = '{256, 64, 65};
      vecs[1] = '{16'hFFFF, 64, 2};
      vecs[2] = '{100, 10, 27};
      vecs[3] = '{1, 1, 257};
      vecs[4] = '{4096, 2047, 129};

      // first-grant latency for a single flow: ceil(cost/rate) edges to cross, one more to grant
      foreach (vecs[v]) begin
         do_reset();
         set_flow(0, 1, vecs[v].rate, vecs[v].size);
         grant_ready = 1'b1;
         wait_valid(2000, n);
         chk("vec_latency", n, vecs[v].exp_edge);
         chk("vec_flow", grant_flow, 0);
         chk("vec_size", grant_size, vecs[v].size);
      end

      // single flow steady state: one grant per 64 cycles
      do_reset();
      set_flow(0, 1, 256, 64);
      grant_ready = 1'b1;
      e = 0; ng = 0; last = 0;
      while (ng < 10 && e < 2000) begin
         @(negedge clk);
         e++;
         if (grant_valid) begin
            if (ng == 0) chk("single_first_edge", e, 65);
            else chk("single_spacing", e - last, 64);
            last = e;
            ng++;
         end
      end
      chk("single_grants_seen", ng, 10);
      @(negedge clk);
      chk("single_count", grant_count, 10);

      // four saturating flows: strict round robin at one grant per 2 cycles
      do_reset();
      for (int i = 0; i < N; i++) set_flow(i, 1, 16'hFFFF, 64);
      grant_ready = 1'b1;
      e = 0; ng = 0; last = 0; prev = -1;
      while (ng < 12 && e < 200) begin
         @(negedge clk);
         e++;
         if (grant_valid) begin
            chk("rr_flow", grant_flow, ng % N);
            chk("rr_no_repeat", (int'(grant_flow) == prev), 0);
            if (ng > 0) chk("rr_spacing", e - last, 2);
            prev = int'(grant_flow);
            last = e;
            ng++;
         end
      end
      chk("rr_grants_seen", ng, 12);

      // backpressure: grant held stable, credit keeps accruing, one deduction on release
      do_reset();
      set_flow(0, 1, 256, 64);
      wait_valid(200, n);
      chk("bp_latency", n, 65);
      chk("bp_credit_at_grant", dut.credit_q[0], 65 * 256);
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         chk("bp_valid", grant_valid, 1);
         chk("bp_flow", grant_flow, 0);
         chk("bp_size", grant_size, 64);
      end
      chk("bp_credit_held", dut.credit_q[0], 16640 + 100 * 256);
      grant_ready = 1'b1;
      @(negedge clk);
      grant_ready = 1'b0;
      chk("bp_credit_after_accept", dut.credit_q[0], 42240 + 256 - 16384);
      chk("bp_count", grant_count, 1);
      chk("bp_valid_drop", grant_valid, 0);

      // saturation: credit clamps at all-ones and the accept stays saturated
      do_reset();
      set_flow(0, 1, 16'hFFFF, 64);
      repeat (65536) @(negedge clk);
      chk("sat_credit_pre", dut.credit_q[0], 64'hFFFF_0000);
      repeat (2) @(negedge clk);
      chk("sat_credit_clamp", dut.credit_q[0], MAXC);
      chk("sat_valid", grant_valid, 1);
      grant_ready = 1'b1;
      @(negedge clk);
      grant_ready = 1'b0;
      chk("sat_credit_after_accept", dut.credit_q[0], MAXC);
      chk("sat_count", grant_count, 1);

      // disable mid-grant; a zero-size flow is never granted
      do_reset();
      set_flow(1, 1, 16'hFFFF, 64);
      set_flow(2, 1, 16'hFFFF, 0);
      wait_valid(50, n);
      chk("dis_flow_granted", grant_flow, 1);
      cfg_enable[1] = 1'b0;
      set_flow(3, 1, 16'hFFFF, 100);
      repeat (3) begin
         @(negedge clk);
         chk("dis_valid_held", grant_valid, 1);
         chk("dis_flow_held", grant_flow, 1);
         chk("dis_size_held", grant_size, 64);
      end
      grant_ready = 1'b1;
      @(negedge clk);
      chk("dis_valid_drop", grant_valid, 0);
      chk("dis_count", grant_count, 1);
      chk("dis_credit1", dut.credit_q[1], 0);
      chk("dis_eligible1", eligible[1], 0);
      g3 = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (grant_valid) begin
            chk("dis_never_flow1", (grant_flow == 1), 0);
            chk("dis_never_flow2", (grant_flow == 2), 0);
            if (grant_flow == 3) g3++;
         end
      end
      chk("dis_flow3_served", (g3 > 0), 1);
      chk("dis_eligible2", eligible[2], 0);

      // asynchronous reset between edges while a grant is pending
      do_reset();
      for (int i = 0; i < N; i++) set_flow(i, 1, 16'hFFFF, 64);
      grant_ready = 1'b1;
      repeat (7) @(negedge clk);
      grant_ready = 1'b0;
      wait_valid(20, n);
      chk("arst_count_before", (grant_count > 0), 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_valid_now", grant_valid, 0);
      chk("arst_count_now", grant_count, 0);
      chk("arst_credit0", dut.credit_q[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      grant_ready = 1'b1;
      wait_valid(20, n);
      chk("arst_first_latency", n, 2);
      chk("arst_first_flow", grant_flow, 0);
      chk("arst_count_after", grant_count, 0);

      // randomized configurations and backpressure, checked every cycle by the model
      do_reset();
      g_rand = 0;
      for (int s = 0; s < 40; s++) begin
         for (int i = 0; i < N; i++)
            set_flow(i, ($urandom_range(0, 3) != 0), $urandom_range(64, 65535),
                     ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 200));
         for (int c = 0; c < 60; c++) begin
            grant_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (grant_valid && grant_ready) g_rand++;
         end
      end
      chk("rand_grants_seen", (g_rand > 0), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
